// File: rtl/axi_slave_mem_if.sv
// AXI3 slave-port bundle as seen downstream of the interconnect (widened IDs).
// Lock/cache/prot fields are carried for completeness; the memory slave ignores them.
interface axi_slave_mem_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]    AWID;
  logic [ADDR_WIDTH-1:0]  AWADDR;
  logic [3:0]             AWLEN;
  logic [2:0]             AWSIZE;
  logic [1:0]             AWBURST;
  logic [1:0]             AWLOCK;
  logic [3:0]             AWCACHE;
  logic [2:0]             AWPROT;
  logic                   AWVALID;
  logic                   AWREADY;

  logic [ID_WIDTH-1:0]    WID;
  logic [BUS_WIDTH-1:0]   WDATA;
  logic [BUS_WIDTH/8-1:0] WSTRB;
  logic                   WLAST;
  logic                   WVALID;
  logic                   WREADY;

  logic [ID_WIDTH-1:0]    BID;
  logic [1:0]             BRESP;
  logic                   BVALID;
  logic                   BREADY;

  logic [ID_WIDTH-1:0]    ARID;
  logic [ADDR_WIDTH-1:0]  ARADDR;
  logic [3:0]             ARLEN;
  logic [1:0]             ARSIZE;
  logic [1:0]             ARBURST;
  logic [1:0]             ARLOCK;
  logic [3:0]             ARCACHE;
  logic [2:0]             ARPROT;
  logic                   ARVALID;
  logic                   ARREADY;

  logic [ID_WIDTH-1:0]    RID;
  logic [BUS_WIDTH-1:0]   RDATA;
  logic [1:0]             RRESP;
  logic                   RLAST;
  logic                   RVALID;
  logic                   RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI3 word-array slave: one write burst and one read burst in flight, independently.
// state  | meaning
// W_IDLE | waiting for AW, AWREADY high
// W_DATA | accepting W beats into memory
// W_RESP | presenting B until BREADY
// R_IDLE | waiting for AR, ARREADY high
// R_DATA | presenting R beats, rdata_q holds the current beat
module axi_slave_mem #(
  parameter int BUS_WIDTH  = 32,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input logic          clk,
  input logic          clr,
  axi_slave_mem_if.slave s
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = BUS_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [BUS_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t            w_state, w_next;
  logic [ID_WIDTH-1:0] w_id;
  logic [IDX_W-1:0]    w_idx;
  logic [3:0]          w_len, w_cnt;
  logic                w_fixed, w_err;
  logic                aw_hs, w_hs, w_last_cnt, w_id_bad, w_mem_we;

  r_state_t             r_state, r_next;
  logic [ID_WIDTH-1:0]  r_id;
  logic [IDX_W-1:0]     r_idx, r_idx_nxt, ar_idx;
  logic [3:0]           r_len, r_cnt;
  logic                 r_fixed, r_err, r_last, ar_hs, r_hs;
  logic [BUS_WIDTH-1:0] rdata_q;

  // ---------------- write channel ----------------
  assign aw_hs      = s.AWVALID && (w_state == W_IDLE);
  assign w_hs       = s.WVALID && (w_state == W_DATA);
  assign w_last_cnt = (w_cnt == w_len);
  assign w_id_bad   = (s.WID != w_id);
  assign w_mem_we   = w_hs && !clr && !w_err && !w_id_bad;

  always_ff @(posedge clk) begin
    if (clr) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s.AWVALID) w_next = W_DATA;
      W_DATA:  if (s.WVALID && (s.WLAST || w_last_cnt)) w_next = W_RESP;
      W_RESP:  if (s.BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s.AWID;
      w_idx   <= s.AWADDR[IDX_W+1:2];
      w_len   <= s.AWLEN;
      w_cnt   <= '0;
      w_fixed <= (s.AWBURST == 2'b00);
      w_err   <= (s.AWSIZE != 3'd2) || s.AWBURST[1];
    end else if (w_hs) begin
      w_idx <= w_fixed ? w_idx : w_idx + 1'b1;
      w_cnt <= w_cnt + 4'd1;
      // WLAST must coincide with the final counted beat
      if (w_id_bad || (s.WLAST != w_last_cnt)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s.WSTRB[b]) mem[w_idx][8*b +: 8] <= s.WDATA[8*b +: 8];
      end
    end
  end

  assign s.AWREADY = (w_state == W_IDLE);
  assign s.WREADY  = (w_state == W_DATA);
  assign s.BVALID  = (w_state == W_RESP);
  assign s.BID     = w_id;
  assign s.BRESP   = {w_err, 1'b0};

  // ---------------- read channel ----------------
  assign ar_hs     = s.ARVALID && (r_state == R_IDLE);
  assign r_hs      = s.RREADY && (r_state == R_DATA);
  assign r_last    = (r_cnt == r_len);
  assign ar_idx    = s.ARADDR[IDX_W+1:2];
  assign r_idx_nxt = r_fixed ? r_idx : r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (clr) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s.ARVALID) r_next = R_DATA;
      R_DATA:  if (s.RREADY && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Memory reads here see pre-edge contents, so a same-edge write returns old data
  always_ff @(posedge clk) begin
    if (clr) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
      rdata_q <= '0;
    end else if (ar_hs) begin
      r_id    <= s.ARID;
      r_idx   <= ar_idx;
      r_len   <= s.ARLEN;
      r_cnt   <= '0;
      r_fixed <= (s.ARBURST == 2'b00);
      r_err   <= (s.ARSIZE != 2'd2) || s.ARBURST[1];
      rdata_q <= mem[ar_idx];
    end else if (r_hs && !r_last) begin
      r_idx   <= r_idx_nxt;
      r_cnt   <= r_cnt + 4'd1;
      rdata_q <= mem[r_idx_nxt];
    end
  end

  assign s.ARREADY = (r_state == R_IDLE);
  assign s.RVALID  = (r_state == R_DATA);
  assign s.RLAST   = (r_state == R_DATA) && r_last;
  assign s.RID     = r_id;
  assign s.RDATA   = rdata_q;
  assign s.RRESP   = {r_err, 1'b0};
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: table of single-beat write/read-back vectors
// plus hand-written burst, stall, reset and collision sequences.
module tb_axi_slave_mem;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  axi_slave_mem_if #(.BUS_WIDTH(32), .ID_WIDTH(2), .ADDR_WIDTH(32)) bus ();

  axi_slave_mem #(.BUS_WIDTH(32), .ID_WIDTH(2), .ADDR_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk(clk),
    .clr(clr),
    .s  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_id, rd_resp;
  int          rd_maxwait;
  logic [1:0]  wr_bid, wr_resp;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    logic [1:0]  arsize;
    logic [1:0]  exp_rresp;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return bus.AWREADY;
      1:       return bus.WREADY;
      2:       return bus.BVALID;
      3:       return bus.ARREADY;
      default: return bus.RVALID;
    endcase
  endfunction

  // Returns at the negedge where the selected ready/valid is seen high
  task automatic hs(input int which, output int waits);
    waits = 0;
    @(negedge clk);
    while (!sel(which) && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      tests++;
      fails++;
      $display("FAIL timeout on channel %0d: got no handshake expected one within 50 cycles", which);
    end
  endtask

  task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                          input logic [3:0] strb, input int wlast_at);
    int w;
    int nb;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    hs(0, w);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    nb = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
    for (int i = 0; i < nb; i++) begin
      bus.WVALID = 1'b1; bus.WID = id; bus.WDATA = base + i; bus.WSTRB = strb;
      bus.WLAST = (i == wlast_at);
      hs(1, w);
      @(posedge clk); #1;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    bus.BREADY = 1'b1;
    hs(2, w);
    wr_bid = bus.BID; wr_resp = bus.BRESP;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] size, input logic [1:0] burst, input int stall_at);
    int w;
    logic [31:0] d0;
    logic        l0;
    rd_maxwait = 0;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    hs(3, w);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        bus.RREADY = 1'b0;
        hs(4, w);
        d0 = bus.RDATA; l0 = bus.RLAST;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          @(negedge clk);
          check($sformatf("stall_rvalid_%0d", k), 64'(bus.RVALID), 64'(1));
          check($sformatf("stall_rdata_%0d", k), 64'(bus.RDATA), 64'(d0));
          check($sformatf("stall_rlast_%0d", k), 64'(bus.RLAST), 64'(l0));
        end
        @(posedge clk); #1;
        bus.RREADY = 1'b1;
      end
      hs(4, w);
      if (w > rd_maxwait) rd_maxwait = w;
      rd_data[i] = bus.RDATA;
      rd_last[i] = bus.RLAST;
      if (i == 0) begin
        rd_id = bus.RID; rd_resp = bus.RRESP;
      end
      @(posedge clk); #1;
    end
    bus.RREADY = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300us");
    $fatal(1);
  end

  initial begin
    int w;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWLOCK = '0; bus.AWCACHE = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.ARLOCK = '0; bus.ARCACHE = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    tbl[0] = '{32'h0,   32'h11223344, 4'hF, 3'd2, 2'b01, 2'b00, 32'h0,  2'd2, 2'b00, 32'h11223344};
    tbl[1] = '{32'h0,   32'hAABBCCDD, 4'h5, 3'd2, 2'b01, 2'b00, 32'h0,  2'd2, 2'b00, 32'h11BB33DD};
    tbl[2] = '{32'h0,   32'hFFFFFFFF, 4'hF, 3'd1, 2'b01, 2'b10, 32'h0,  2'd2, 2'b00, 32'h11BB33DD};
    tbl[3] = '{32'h8,   32'h00000055, 4'hF, 3'd2, 2'b01, 2'b00, 32'h8,  2'd2, 2'b00, 32'h00000055};
    tbl[4] = '{32'h4,   32'hCAFEF00D, 4'hF, 3'd2, 2'b00, 2'b00, 32'h4,  2'd2, 2'b00, 32'hCAFEF00D};
    tbl[5] = '{32'h4,   32'h12345678, 4'h8, 3'd2, 2'b01, 2'b00, 32'h4,  2'd2, 2'b00, 32'h12FEF00D};
    tbl[6] = '{32'hC,   32'h00000077, 4'hF, 3'd2, 2'b10, 2'b10, 32'h0,  2'd2, 2'b00, 32'h11BB33DD};
    tbl[7] = '{32'h30,  32'h00000009, 4'hF, 3'd2, 2'b01, 2'b00, 32'h30, 2'd1, 2'b10, 32'h00000009};
    tbl[8] = '{32'h400, 32'hDEAD0001, 4'hF, 3'd2, 2'b01, 2'b00, 32'h0,  2'd2, 2'b00, 32'hDEAD0001};
    tbl[9] = '{32'h0,   32'h0BAD0BAD, 4'hF, 3'd2, 2'b11, 2'b10, 32'h0,  2'd2, 2'b00, 32'hDEAD0001};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(bus.AWREADY), 64'(1));
    check("rst_arready", 64'(bus.ARREADY), 64'(1));
    check("rst_wready",  64'(bus.WREADY),  64'(0));
    check("rst_bvalid",  64'(bus.BVALID),  64'(0));
    check("rst_rvalid",  64'(bus.RVALID),  64'(0));
    check("rst_rlast",   64'(bus.RLAST),   64'(0));
    check("rst_resp",    64'({bus.BRESP, bus.RRESP, bus.BID, bus.RID}), 64'(0));
    check("rst_rdata",   64'(bus.RDATA),   64'(0));
    clr = 1'b0;
    @(posedge clk); #1;

    // 4-beat INCR write then read back
    do_write(2'b01, 32'h10, 4'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 3);
    check("t1_bid", 64'(wr_bid), 64'(2'b01));
    check("t1_bresp", 64'(wr_resp), 64'(2'b00));
    do_read(2'b10, 32'h10, 4'd3, 2'd2, 2'b01, -1);
    check("t1_rid", 64'(rd_id), 64'(2'b10));
    check("t1_rresp", 64'(rd_resp), 64'(2'b00));
    check("t1_nobubble", 64'(rd_maxwait), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_rdata_%0d", i), 64'(rd_data[i]), 64'(32'hA0 + i));
      check($sformatf("t1_rlast_%0d", i), 64'(rd_last[i]), 64'(i == 3));
    end

    // Table of single-beat write/read-back vectors
    for (int v = 0; v < 10; v++) begin
      do_write(2'b11, tbl[v].waddr, 4'd0, tbl[v].awsize, tbl[v].awburst, tbl[v].wdata, tbl[v].strb, 0);
      check($sformatf("vec%0d_bid", v), 64'(wr_bid), 64'(2'b11));
      check($sformatf("vec%0d_bresp", v), 64'(wr_resp), 64'(tbl[v].exp_bresp));
      do_read(2'b00, tbl[v].raddr, 4'd0, tbl[v].arsize, 2'b01, -1);
      check($sformatf("vec%0d_rresp", v), 64'(rd_resp), 64'(tbl[v].exp_rresp));
      check($sformatf("vec%0d_rdata", v), 64'(rd_data[0]), 64'(tbl[v].exp_rdata));
      check($sformatf("vec%0d_rlast", v), 64'(rd_last[0]), 64'(1));
    end

    // FIXED read stays on one word
    do_read(2'b01, 32'h8, 4'd2, 2'd2, 2'b00, -1);
    for (int i = 0; i < 3; i++)
      check($sformatf("fixed_rdata_%0d", i), 64'(rd_data[i]), 64'(32'h55));
    check("fixed_rlast", 64'({rd_last[0], rd_last[1], rd_last[2]}), 64'(3'b001));

    // Early WLAST, then missing WLAST
    do_write(2'b00, 32'h20, 4'd3, 3'd2, 2'b01, 32'hC0, 4'hF, 1);
    check("early_wlast_bresp", 64'(wr_resp), 64'(2'b10));
    do_write(2'b10, 32'h28, 4'd1, 3'd2, 2'b01, 32'hC8, 4'hF, 99);
    check("missing_wlast_bresp", 64'(wr_resp), 64'(2'b10));

    // RREADY stalled mid-burst
    do_read(2'b11, 32'h10, 4'd3, 2'd2, 2'b01, 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_beat_%0d", i), 64'(rd_data[i]), 64'(32'hA0 + i));
      check($sformatf("stall_last_%0d", i), 64'(rd_last[i]), 64'(i == 3));
    end

    // Index wrap from MEM_DEPTH-1 to 0
    do_write(2'b00, 32'h3FC, 4'd1, 3'd2, 2'b01, 32'hB0, 4'hF, 1);
    check("wrap_bresp", 64'(wr_resp), 64'(2'b00));
    do_read(2'b00, 32'h0, 4'd0, 2'd2, 2'b01, -1);
    check("wrap_idx0", 64'(rd_data[0]), 64'(32'hB1));
    do_read(2'b00, 32'h3FC, 4'd1, 2'd2, 2'b01, -1);
    check("wrap_rd_top", 64'(rd_data[0]), 64'(32'hB0));
    check("wrap_rd_idx0", 64'(rd_data[1]), 64'(32'hB1));

    // clr during W_DATA aborts the burst
    bus.AWID = 2'b00; bus.AWADDR = 32'h60; bus.AWLEN = 4'd3; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
    bus.AWVALID = 1'b1;
    hs(0, w);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b1; bus.WID = 2'b00; bus.WDATA = 32'hEE; bus.WSTRB = 4'hF; bus.WLAST = 1'b0;
    hs(1, w);
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_awready", 64'(bus.AWREADY), 64'(1));
    check("clr_bvalid",  64'(bus.BVALID),  64'(0));
    check("clr_wready",  64'(bus.WREADY),  64'(0));
    @(posedge clk); #1;
    do_write(2'b01, 32'h64, 4'd0, 3'd2, 2'b01, 32'hE5, 4'hF, 0);
    check("post_clr_bid", 64'(wr_bid), 64'(2'b01));
    check("post_clr_bresp", 64'(wr_resp), 64'(2'b00));
    do_read(2'b00, 32'h64, 4'd0, 2'd2, 2'b01, -1);
    check("post_clr_rdata", 64'(rd_data[0]), 64'(32'hE5));

    // W beat and AR handshake on the same edge to the same word
    do_write(2'b00, 32'h40, 4'd0, 3'd2, 2'b01, 32'h1111, 4'hF, 0);
    bus.AWID = 2'b01; bus.AWADDR = 32'h40; bus.AWLEN = 4'd0; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
    bus.AWVALID = 1'b1;
    hs(0, w);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b1; bus.WID = 2'b01; bus.WDATA = 32'h2222; bus.WSTRB = 4'hF; bus.WLAST = 1'b1;
    bus.ARID = 2'b10; bus.ARADDR = 32'h40; bus.ARLEN = 4'd0; bus.ARSIZE = 2'd2; bus.ARBURST = 2'b01;
    bus.ARVALID = 1'b1;
    @(negedge clk);
    check("coll_wready",  64'(bus.WREADY),  64'(1));
    check("coll_arready", 64'(bus.ARREADY), 64'(1));
    @(posedge clk); #1;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    @(negedge clk);
    check("coll_rvalid", 64'(bus.RVALID), 64'(1));
    check("coll_rdata_old", 64'(bus.RDATA), 64'(32'h1111));
    check("coll_rid", 64'(bus.RID), 64'(2'b10));
    check("coll_rlast", 64'(bus.RLAST), 64'(1));
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
    bus.BREADY = 1'b1;
    hs(2, w);
    check("coll_bid", 64'(bus.BID), 64'(2'b01));
    check("coll_bresp", 64'(bus.BRESP), 64'(2'b00));
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    do_read(2'b00, 32'h40, 4'd0, 2'd2, 2'b01, -1);
    check("coll_rdata_new", 64'(rd_data[0]), 64'(32'h2222));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
